// File: rtl/alu_hs.sv
// alu_hs: clocked ALU with valid/ready handshakes on both the operand and result sides.
// Single-cycle logic/arith ops, iterative one-bit-per-cycle shifts, and an optional
// iterative shift-add multiplier enabled by defining ALU_HS_MUL_EN.
// Without ALU_HS_MUL_EN, opcode 9 decodes as illegal and no multiplier state exists.
module alu_hs #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             err
);

   // counter must hold WIDTH (multiply iterations) as well as any shift amount
   localparam int CW = SHW + 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_OR  = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_CMP = 4'd7;
   localparam logic [3:0] OP_SHR = 4'd8;
`ifdef ALU_HS_MUL_EN
   localparam logic [3:0] OP_MUL = 4'd9;
`endif

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state_q, state_d;
   logic [3:0]       opc_q, opc_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             cry_q, cry_d;
   logic             zero_q, zero_d;
   logic             err_q, err_d;
`ifdef ALU_HS_MUL_EN
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
`endif

   logic [SHW-1:0]   shamt;
   logic             accept, is_shift, is_mul, go_exec, last;
   logic [WIDTH-1:0] sc_res, step_acc;
   logic             sc_cry, sc_err, step_cry;

   assign shamt    = b[SHW-1:0];
   assign accept   = in_valid && (state_q == IDLE);
   assign is_shift = (op == OP_SHL) || (op == OP_SHR);
`ifdef ALU_HS_MUL_EN
   assign is_mul   = (op == OP_MUL);
`else
   assign is_mul   = 1'b0;
`endif
   // zero-length shifts finish like single-cycle ops
   assign go_exec  = (is_shift && (shamt != '0)) || is_mul;
   assign last     = (cnt_q == CW'(1));

   // single-cycle result, evaluated from the live inputs at the accept edge
   always_comb begin
      sc_res = '0;
      sc_cry = 1'b0;
      sc_err = 1'b0;
      case (op)
         OP_ADD: {sc_cry, sc_res} = {1'b0, a} + {1'b0, b};
         OP_SUB: begin
            sc_res = a - b;
            sc_cry = (a < b);
         end
         OP_OR:  sc_res = a | b;
         OP_AND: sc_res = a & b;
         OP_XOR: sc_res = a ^ b;
         OP_NOT: sc_res = ~a;
         OP_CMP: sc_res = (a < b) ? WIDTH'(1) : ((a == b) ? WIDTH'(2) : WIDTH'(3));
         OP_SHL, OP_SHR: sc_res = a;
`ifdef ALU_HS_MUL_EN
         OP_MUL: sc_res = '0;
`endif
         default: sc_err = 1'b1;
      endcase
   end

   // one iteration of the multi-cycle op latched in opc_q
   always_comb begin
      step_acc = acc_q;
      step_cry = 1'b0;
      case (opc_q)
         OP_SHL: begin
            step_acc = acc_q << 1;
            step_cry = acc_q[WIDTH-1];
         end
         OP_SHR: begin
            step_acc = acc_q >> 1;
            step_cry = acc_q[0];
         end
`ifdef ALU_HS_MUL_EN
         OP_MUL: step_acc = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif
         default: step_acc = acc_q;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = go_exec ? EXEC : DONE;
         EXEC:    if (last) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: handshake flags decode straight from the state
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   // datapath next-state; result and flags only change when DONE is entered
   always_comb begin
      opc_d  = opc_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      res_d  = res_q;
      cry_d  = cry_q;
      zero_d = zero_q;
      err_d  = err_q;
`ifdef ALU_HS_MUL_EN
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
`endif
      if (accept) begin
         opc_d = op;
         acc_d = is_mul ? '0 : a;
         cnt_d = is_mul ? CW'(WIDTH) : CW'(shamt);
`ifdef ALU_HS_MUL_EN
         mcand_d  = a;
         mplier_d = b;
`endif
         if (!go_exec) begin
            res_d  = sc_res;
            cry_d  = sc_cry;
            err_d  = sc_err;
            zero_d = (sc_res == '0);
         end
      end else if (state_q == EXEC) begin
         acc_d = step_acc;
         cnt_d = cnt_q - CW'(1);
`ifdef ALU_HS_MUL_EN
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
`endif
         if (last) begin
            res_d  = step_acc;
            cry_d  = step_cry;
            err_d  = 1'b0;
            zero_d = (step_acc == '0);
         end
      end
   end

   // datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opc_q  <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         res_q  <= '0;
         cry_q  <= 1'b0;
         zero_q <= 1'b0;
         err_q  <= 1'b0;
`ifdef ALU_HS_MUL_EN
         mcand_q  <= '0;
         mplier_q <= '0;
`endif
      end else begin
         opc_q  <= opc_d;
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         res_q  <= res_d;
         cry_q  <= cry_d;
         zero_q <= zero_d;
         err_q  <= err_d;
`ifdef ALU_HS_MUL_EN
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
`endif
      end
   end

   assign result = res_q;
   assign zero   = zero_q;
   assign carry  = cry_q;
   assign err    = err_q;

endmodule

// File: tb/tb_alu_hs.sv
// tb_alu_hs: table-driven directed vectors for alu_hs (WIDTH=32) plus hand-written
// sequences for backpressure, ignored input during EXEC and reset mid-operation.
module tb_alu_hs;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [3:0]    op;
   logic [W-1:0]  a, b, result;
   logic          zero, carry, err;

   int n_run  = 0;
   int n_fail = 0;

   alu_hs #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .carry(carry), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [3:0] op;
      logic [31:0] a, b, res;
      logic       cry, zr, er;
      int         lat;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string nm, input logic [3:0] o, input logic [31:0] aa, bb, rr,
                               input logic cc, zz, ee, input int ll);
      vec_t v;
      v.name = nm; v.op = o; v.a = aa; v.b = bb; v.res = rr;
      v.cry = cc; v.zr = zz; v.er = ee; v.lat = ll;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // present an op at a negedge and release in_valid just after the accept edge
   task automatic start_op(input string nm, input logic [3:0] o, input logic [31:0] aa, bb);
      @(negedge clk);
      chk({nm, " in_ready@issue"}, in_ready, 1);
      op = o; a = aa; b = bb; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // lat counts negedges after the accept edge until out_valid is seen
   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 200);
   endtask

   // consume the result and check the handshake/retention behaviour
   task automatic finish_op(input string nm, input logic [31:0] exp_res);
      chk({nm, " in_ready@done"}, in_ready, 0);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk({nm, " in_ready_after"}, in_ready, 1);
      chk({nm, " out_valid_after"}, out_valid, 0);
      chk({nm, " result_retained"}, result, exp_res);
   endtask

   initial begin
      int lat, cnt;
      logic [31:0] held;

      vecs.push_back(mk("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1,  32'd0,          1, 1, 0, 1));
      vecs.push_back(mk("add",      4'd0, 32'd5,         32'd7,  32'd12,         0, 0, 0, 1));
      vecs.push_back(mk("sub_brw",  4'd1, 32'd3,         32'd5,  32'hFFFF_FFFE,  1, 0, 0, 1));
      vecs.push_back(mk("sub_eq",   4'd1, 32'd5,         32'd5,  32'd0,          0, 1, 0, 1));
      vecs.push_back(mk("or",       4'd2, 32'hF0,        32'h0F, 32'hFF,         0, 0, 0, 1));
      vecs.push_back(mk("and",      4'd3, 32'hF0,        32'h3C, 32'h30,         0, 0, 0, 1));
      vecs.push_back(mk("xor",      4'd4, 32'hFF,        32'h0F, 32'hF0,         0, 0, 0, 1));
      vecs.push_back(mk("not",      4'd5, 32'd0,         32'd9,  32'hFFFF_FFFF,  0, 0, 0, 1));
      vecs.push_back(mk("cmp_eq",   4'd7, 32'd7,         32'd7,  32'd2,          0, 0, 0, 1));
      vecs.push_back(mk("cmp_gt",   4'd7, 32'd9,         32'd2,  32'd3,          0, 0, 0, 1));
      vecs.push_back(mk("cmp_lt",   4'd7, 32'd1,         32'd5,  32'd1,          0, 0, 0, 1));
      vecs.push_back(mk("shl4",     4'd6, 32'h8000_0001, 32'd4,  32'h10,         0, 0, 0, 5));
      vecs.push_back(mk("shl_hib",  4'd6, 32'd5,         32'h21, 32'hA,          0, 0, 0, 2));
      vecs.push_back(mk("shl_n0",   4'd6, 32'd5,         32'h20, 32'd5,          0, 0, 0, 1));
      vecs.push_back(mk("shr0",     4'd8, 32'd1,         32'd0,  32'd1,          0, 0, 0, 1));
      vecs.push_back(mk("shr1",     4'd8, 32'd3,         32'd1,  32'd1,          1, 0, 0, 2));
      vecs.push_back(mk("shr31",    4'd8, 32'hC000_0000, 32'd31, 32'd1,          1, 0, 0, 32));
      vecs.push_back(mk("ill12",    4'd12, 32'd4,        32'd4,  32'd0,          0, 1, 1, 1));
      vecs.push_back(mk("ill15",    4'd15, 32'hFFFF_FFFF, 32'd1, 32'd0,          0, 1, 1, 1));
`ifdef ALU_HS_MUL_EN
      vecs.push_back(mk("mul",      4'd9, 32'd1234,      32'd5678, 32'd7006652,  0, 0, 0, 33));
`else
      vecs.push_back(mk("mul_off",  4'd9, 32'd1234,      32'd5678, 32'd0,        0, 1, 1, 1));
`endif

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      chk("rst in_ready",  in_ready, 1);
      chk("rst out_valid", out_valid, 0);
      chk("rst result",    result, 0);
      chk("rst zero",      zero, 0);
      chk("rst carry",     carry, 0);
      chk("rst err",       err, 0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         start_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b);
         wait_valid(lat);
         chk({vecs[i].name, " latency"}, lat, vecs[i].lat);
         chk({vecs[i].name, " result"}, result, vecs[i].res);
         chk({vecs[i].name, " carry"}, carry, vecs[i].cry);
         chk({vecs[i].name, " zero"}, zero, vecs[i].zr);
         chk({vecs[i].name, " err"}, err, vecs[i].er);
         finish_op(vecs[i].name, vecs[i].res);
      end

      // backpressure: result held for 10 cycles, new input ignored meanwhile
      start_op("bp", 4'd4, 32'hAA, 32'h55);
      wait_valid(lat);
      chk("bp latency", lat, 1);
      held = result;
      chk("bp result", held, 32'hFF);
      op = 4'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp stable result", result, 32'hFF);
         chk("bp stable valid", out_valid, 1);
         chk("bp in_ready low", in_ready, 0);
      end
      in_valid = 1'b0;
      finish_op("bp", 32'hFF);

      // input pulsed during a shift's EXEC phase is ignored
      start_op("exec_ign", 4'd8, 32'hF8, 32'd4);
      @(negedge clk);
      op = 4'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid(lat);
      chk("exec_ign latency", lat + 2, 5);
      chk("exec_ign result", result, 32'hF);
      chk("exec_ign carry", carry, 1);
      finish_op("exec_ign", 32'hF);
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("exec_ign no extra", cnt, 0);

      // reset in the middle of a long shift aborts it
      start_op("rst_mid", 4'd6, 32'd1, 32'd31);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid out_valid", out_valid, 0);
      chk("rst_mid result", result, 0);
      chk("rst_mid in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("rst_mid no output", cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
